// File: rtl/ram_stream_rd_pkg.sv
// ---------------------------------------------------------------------------
// ram_stream_rd_pkg
//   Shared constants for the RAM streaming reader: FSM state encoding,
//   output FIFO depth, and a modulo pointer-increment helper for that FIFO.
// ---------------------------------------------------------------------------
package ram_stream_rd_pkg;

    // Output FIFO depth. The read credit rule uses it too, so keep it here.
    localparam int FIFO_DEPTH = 3;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    // FSM state encoding.
    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] ST_READ = 1'b1;

    // FIFO pointer increment with wrap at FIFO_DEPTH (depth is not a power of 2).
    function automatic logic [FIFO_CNT_W-1:0] ptr_inc(input logic [FIFO_CNT_W-1:0] p);
        return (p == FIFO_CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo_small.sv
// ---------------------------------------------------------------------------
// sync_fifo_small
//   Small synchronous FIFO of FIFO_DEPTH entries, first-word-fall-through:
//   pop_data always shows the head entry.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write one entry (ignored when full)
//   pop              remove the head entry (ignored when empty)
//   pop_data         head entry
//   empty            no entries stored
//   count            number of entries stored (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module sync_fifo_small
    import ram_stream_rd_pkg::*;
#(
    parameter int WIDTH = 257
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_CNT_W-1:0] wr_ptr;
    logic [FIFO_CNT_W-1:0] rd_ptr;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_rd.sv
// ---------------------------------------------------------------------------
// ram_stream_rd
//   Turns a (start address, length) read command into a valid/ready stream
//   of RAM words. Reads are issued to a synchronous RAM (data one cycle after
//   read_en) and captured in a 3-entry FIFO. A read is only issued while
//   fifo_count + inflight < 3, so every issued read has a FIFO slot waiting
//   for it even if the sink stalls.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; valid, once high, holds its payload until that edge. This
//   applies to cmd_valid/cmd_ready and out_valid/out_ready.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_addr, cmd_len     first word address, word count (0..SRAM_WORD)
//   addr_r, read_en       RAM read port (addr_r is 0 when read_en is 0);
//                         the block has no RAM write port
//   ram_rdata             RAM data, valid the cycle after read_en
//   out_valid/out_ready   output stream handshake
//   out_data, out_last    stream word, last-word-of-command flag
//   busy                  command active, read in flight or FIFO non-empty
//   state_dbg             current FSM state
// ---------------------------------------------------------------------------
module ram_stream_rd
    import ram_stream_rd_pkg::*;
#(
    parameter int SRAM_WIDTH      = 256,
    parameter int SRAM_WORD       = 64,
    parameter int SRAM_ADDR_WIDTH = $clog2(SRAM_WORD),
    parameter int LEN_WIDTH       = SRAM_ADDR_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    output logic [SRAM_ADDR_WIDTH-1:0] addr_r,
    output logic                       read_en,
    input  logic [SRAM_WIDTH-1:0]      ram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SRAM_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic [STATE_W-1:0]         state_dbg
);

    logic [STATE_W-1:0]         state;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr_next;
    logic [LEN_WIDTH-1:0]       remaining;
    logic                       inflight;
    logic                       inflight_last;
    logic                       issue_last;
    logic                       cmd_fire;
    logic [FIFO_CNT_W:0]        credit_used;

    logic [FIFO_CNT_W-1:0]      fifo_count;
    logic                       fifo_empty;
    logic [SRAM_WIDTH:0]        fifo_head;

    assign state_dbg = state;
    assign cmd_ready = (state == ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Words already owed to the FIFO: stored ones plus the read in flight.
    assign credit_used = {1'b0, fifo_count} + (FIFO_CNT_W + 1)'(inflight);
    assign read_en     = (state == ST_READ) &&
                         (credit_used < (FIFO_CNT_W + 1)'(FIFO_DEPTH));
    assign addr_r      = read_en ? rd_addr : '0;
    assign issue_last  = read_en && (remaining == LEN_WIDTH'(1));

    // Address wraps at SRAM_WORD, which need not be a power of two.
    assign rd_addr_next = (rd_addr == SRAM_ADDR_WIDTH'(SRAM_WORD - 1)) ? '0
                                                                        : rd_addr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rd_addr       <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            // Tag travels with the read so the FIFO entry knows it is last.
            inflight      <= read_en;
            inflight_last <= issue_last;
            case (state)
                ST_IDLE: begin
                    // A zero-length command is accepted and simply dropped.
                    if (cmd_fire && (cmd_len != '0)) begin
                        state     <= ST_READ;
                        rd_addr   <= cmd_addr;
                        remaining <= cmd_len;
                    end
                end
                ST_READ: begin
                    if (read_en) begin
                        rd_addr   <= rd_addr_next;
                        remaining <= remaining - 1'b1;
                        if (issue_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo_small #(
        .WIDTH (SRAM_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({ram_rdata, inflight_last}),
        .pop       (out_valid && out_ready),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Payload is forced to 0 while empty so stale entries never show.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_head[SRAM_WIDTH:1] : '0;
    assign out_last  = out_valid && fifo_head[0];
    assign busy      = (state != ST_IDLE) || inflight || !fifo_empty;

endmodule
